// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver: pin sync, ws framing lock, stereo sample output with vld strobe
module i2s_rx #(
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 24,
    parameter int OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    I2S_sclk,
    input  logic                    I2S_ws,
    input  logic                    I2S_data,
    output logic signed [OUT_W-1:0] lft_chnnl,
    output logic signed [OUT_W-1:0] rght_chnnl,
    output logic                    vld
);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    localparam logic [5:0] SLOT_CNT = 6'(SLOT_BITS);
    localparam logic [5:0] DATA_CNT = 6'(DATA_BITS);

    // [0],[1] are the metastability stages; sclk_q[2] is the edge-detect history.
    // The ws history stage is ws_prev_q, taken at sclk rate.
    logic [2:0] sclk_q;
    logic [1:0] ws_q;
    logic [1:0] data_q;

    logic sclk_rise;
    logic ws_s;
    logic dat_s;

    state_t                 state_q;
    logic [5:0]             bit_cnt_q;
    logic [5:0]             bit_cnt_d;
    logic [2*DATA_BITS-1:0] shft_q;
    logic                   ws_prev_q;
    logic                   slot_ws;
    logic [OUT_W-1:0]       lft_q;
    logic [OUT_W-1:0]       rght_q;
    logic                   vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ws_q   <= '0;
            data_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], I2S_sclk};
            ws_q   <= {ws_q[0], I2S_ws};
            data_q <= {data_q[0], I2S_data};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ws_s      = ws_q[1];
    assign dat_s     = data_q[1];
    assign bit_cnt_d = bit_cnt_q + 6'd1;
    assign slot_ws   = (state_q == RIGHT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SYNC;
            bit_cnt_q <= '0;
            shft_q    <= '0;
            ws_prev_q <= 1'b0;
            lft_q     <= '0;
            rght_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (sclk_rise) begin
                ws_prev_q <= ws_s;
                case (state_q)
                    SYNC: begin
                        if (ws_prev_q && !ws_s) begin
                            state_q   <= LEFT;
                            bit_cnt_q <= '0;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (bit_cnt_d < SLOT_CNT) begin
                            if (ws_s == slot_ws) begin
                                bit_cnt_q <= bit_cnt_d;
                                if (bit_cnt_d <= DATA_CNT) begin
                                    shft_q <= {shft_q[2*DATA_BITS-2:0], dat_s};
                                end
                            end else begin
                                state_q <= SYNC;
                            end
                        end else if (ws_s != slot_ws) begin
                            // The closing ws edge doubles as the opening edge of the next slot.
                            bit_cnt_q <= '0;
                            if (state_q == LEFT) begin
                                state_q <= RIGHT;
                            end else begin
                                state_q <= LEFT;
                                lft_q   <= shft_q[2*DATA_BITS-1 -: OUT_W];
                                rght_q  <= shft_q[DATA_BITS-1 -: OUT_W];
                                vld_q   <= 1'b1;
                            end
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign vld        = vld_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - randomized frame-level bench for i2s_rx with expected-sample queue
module tb_i2s_rx;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               I2S_sclk = 1'b0;
    logic               I2S_ws = 1'b0;
    logic               I2S_data = 1'b0;
    logic signed [15:0] lft_chnnl;
    logic signed [15:0] rght_chnnl;
    logic               vld;

    i2s_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I2S_sclk  (I2S_sclk),
        .I2S_ws    (I2S_ws),
        .I2S_data  (I2S_data),
        .lft_chnnl (lft_chnnl),
        .rght_chnnl(rght_chnnl),
        .vld       (vld)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          half = 4;
    longint      cyc = 0;
    logic [31:0] exp_q[$];
    int          n_vld = 0;
    bit          spacing_on = 1'b0;

    logic        mon_prev_v = 1'b0;
    longint      mon_last = 0;
    bit          mon_have = 1'b0;
    logic [31:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic send_bit(input logic ws, input logic d);
        I2S_sclk = 1'b0;
        I2S_ws   = ws;
        I2S_data = d;
        repeat (half) @(negedge clk);
        I2S_sclk = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    // Slot bit 0 is the ws-edge bit; bits 1..24 carry the word MSB first.
    task automatic send_slot(input logic ws, input logic [23:0] w, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (i >= 1 && i <= 24) b = w[24-i];
            send_bit(ws, b);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input bit expect_out);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
        if (expect_out) exp_q.push_back({l[23:8], r[23:8]});
    endtask

    // Close the last frame with a ws fall, then break lock and idle with ws high.
    task automatic close_and_resync();
        send_bit(1'b0, 1'b0);
        send_slot(1'b1, 24'h0, 32);
    endtask

    task automatic drain(input string tag, input int base, input int want_n);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk({"drain_", tag}, 32'(exp_q.size()), 32'd0);
        chk({"nvld_", tag}, 32'(n_vld - base), 32'(want_n));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev_v) chk("vld_width", {31'b0, vld}, 32'd0);
            if (vld) begin
                n_vld++;
                chk("vld_has_exp", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("lft", {16'h0, lft_chnnl}, {16'h0, mon_e[31:16]});
                    chk("rght", {16'h0, rght_chnnl}, {16'h0, mon_e[15:0]});
                end
                if (spacing_on && mon_have) chk("spacing", 32'(cyc - mon_last), 32'(128 * half));
                mon_have = spacing_on;
                mon_last = cyc;
            end
            mon_prev_v = vld;
        end
    end

    initial begin
        int base;
        logic [23:0] l24;
        logic [23:0] r24;
        logic [15:0] bl [4];
        logic [15:0] br [4];
        bl[0] = 16'h8000; br[0] = 16'h7FFF;
        bl[1] = 16'h0001; br[1] = 16'hFFFF;
        bl[2] = 16'h1234; br[2] = 16'hFEDC;
        bl[3] = 16'hDEAD; br[3] = 16'hBEEF;

        // Reset state, then release reset in the middle of a left slot.
        half = 4;
        send_slot(1'b0, 24'h5A5A5A, 10);
        chk("rst_lft", {16'h0, lft_chnnl}, 32'd0);
        chk("rst_rght", {16'h0, rght_chnnl}, 32'd0);
        chk("rst_vld", {31'b0, vld}, 32'd0);
        rst_n = 1'b1;
        base = n_vld;
        send_slot(1'b0, 24'h5A5A5A, 14);
        send_slot(1'b1, 24'h0F0F0F, 32);
        send_frame(24'h3C5A96, 24'hC0FFEE, 1'b1);
        close_and_resync();
        drain("startup", base, 1);

        // Clean frame.
        base = n_vld;
        send_frame(24'hA5C3F0, 24'h123456, 1'b1);
        close_and_resync();
        drain("clean", base, 1);

        // Back-to-back frames, exactly 64 sclk apart.
        base = n_vld;
        spacing_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_frame({bl[k], 8'($urandom)}, {br[k], 8'($urandom)}, 1'b1);
        end
        close_and_resync();
        drain("b2b", base, 4);
        spacing_on = 1'b0;

        // Framing error: ws rises when the left count would become 20.
        base = n_vld;
        send_slot(1'b0, 24'hFFFFFF, 20);
        send_slot(1'b1, 24'hFFFFFF, 32);
        send_frame(24'h4B1E77, 24'h9D0C21, 1'b1);
        close_and_resync();
        drain("ferr", base, 1);

        // Reset during a right slot after one good frame.
        base = n_vld;
        send_frame(24'hA5C3F0, 24'h123456, 1'b1);
        send_slot(1'b0, 24'h111111, 32);
        send_slot(1'b1, 24'h222222, 10);
        chk("pre_rst_lft", {16'h0, lft_chnnl}, 32'h0000A5C3);
        chk("pre_rst_rght", {16'h0, rght_chnnl}, 32'h00001234);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lft", {16'h0, lft_chnnl}, 32'd0);
        chk("async_rst_rght", {16'h0, rght_chnnl}, 32'd0);
        chk("async_rst_vld", {31'b0, vld}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_slot(1'b1, 24'h0, 32);
        send_frame(24'h6E2B90, 24'hF1D3A7, 1'b1);
        close_and_resync();
        drain("rstmid", base, 2);

        // Minimum clock ratio with random data.
        half = 2;
        base = n_vld;
        for (int k = 0; k < 100; k++) begin
            l24 = 24'($urandom);
            r24 = 24'($urandom);
            send_frame(l24, r24, 1'b1);
        end
        close_and_resync();
        drain("ratio4", base, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
